multicycle_control: RTL and testbench

Multi-cycle control unit for the custom 32-bit MIPS-style core. It sits directly downstream of the word-indexed instruction memory. It latches the fetched word into the instruction register (IR) and decodes opcode[31:26]. It then sequences FETCH/DECODE/EXEC/MEM/WB, driving register-file addresses, ALU, memory, write-back and PC-update strobes for every instruction in the ISA.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_decode.sv | 76 +++++++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU functions, PC-source selects and the decoded instruction class.
package mc_pkg;

    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b010111;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LUI  = 6'b111010;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam logic [3:0] ALU_ADD       = 4'd0;
    localparam logic [3:0] ALU_SLT       = 4'd1;
    localparam logic [3:0] ALU_PASS_B    = 4'd2;
    localparam logic [3:0] ALU_LUI_MERGE = 4'd3;
    localparam logic [3:0] ALU_SUB       = 4'd4;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd2;

    typedef enum logic [3:0] {
        CL_NOOP,
        CL_J,
        CL_ALU_RR,
        CL_ADDI,
        CL_LI,
        CL_LUI,
        CL_LWI,
        CL_SWI,
        CL_BNE,
        CL_BLT,
        CL_BLE,
        CL_ILLEGAL
    } instr_class_e;

    function automatic logic is_branch(input instr_class_e c);
        return (c == CL_BNE) || (c == CL_BLT) || (c == CL_BLE);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR to instruction class, register read
// addresses, immediate and ALU controls.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
) (
    input  logic [31:0]       ir,
    output instr_class_e      iclass,
    output logic [REG_AW-1:0] ra_a,
    output logic [REG_AW-1:0] ra_b,
    output logic [31:0]       imm,
    output logic [3:0]        alu_op,
    output logic              alu_src_b
);

    logic [OP_W-1:0] opcode;
    logic            sign_ext;
    logic            a_from_rd;

    assign opcode = ir[31 -: OP_W];

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        iclass    = CL_ILLEGAL;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        sign_ext  = 1'b0;
        a_from_rd = 1'b0;
        case (opcode)
            OP_NOOP: iclass = CL_NOOP;
            OP_J:    iclass = CL_J;
            OP_ADD:  iclass = CL_ALU_RR;
            OP_SLT: begin
                iclass = CL_ALU_RR;
                alu_op = ALU_SLT;
            end
            OP_BNE, OP_BLT, OP_BLE: begin
                iclass    = (opcode == OP_BNE) ? CL_BNE :
                            (opcode == OP_BLT) ? CL_BLT : CL_BLE;
                alu_op    = ALU_SUB;
                sign_ext  = 1'b1;
                a_from_rd = 1'b1;
            end
            OP_ADDI: begin
                iclass    = CL_ADDI;
                alu_src_b = 1'b1;
                sign_ext  = 1'b1;
            end
            OP_LI: begin
                iclass    = CL_LI;
                alu_op    = ALU_PASS_B;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                iclass    = CL_LUI;
                alu_op    = ALU_LUI_MERGE;
                alu_src_b = 1'b1;
                a_from_rd = 1'b1;
            end
            OP_LWI, OP_SWI: begin
                iclass    = (opcode == OP_LWI) ? CL_LWI : CL_SWI;
                alu_op    = ALU_PASS_B;
                alu_src_b = 1'b1;
                a_from_rd = (opcode == OP_SWI);
            end
            default: iclass = CL_ILLEGAL;
        endcase

        ra_a = a_from_rd ? ir[25:21] : ir[20:16];
        ra_b = is_branch(iclass) ? ir[20:16] : ir[15:11];
        imm  = sign_ext ? {{16{ir[15]}}, ir[15:0]} : {16'h0000, ir[15:0]};
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with instruction register.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instruction,
    input  logic              alu_eq,
    input  logic              alu_lt,
    output logic [31:0]       ir,
    output logic [REG_AW-1:0] ra_a,
    output logic [REG_AW-1:0] ra_b,
    output logic [REG_AW-1:0] wa,
    output logic [31:0]       imm,
    output logic [3:0]        alu_op,
    output logic              alu_src_b,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              wb_src,
    output logic              illegal,
    output logic [2:0]        state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    logic [2:0]   state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    instr_class_e iclass;
    logic         br_taken;

    mc_decode #(
        .OP_W   (OP_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .ir        (ir_q),
        .iclass    (iclass),
        .ra_a      (ra_a),
        .ra_b      (ra_b),
        .imm       (imm),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b)
    );

    assign ir    = ir_q;
    assign state = state_q;
    assign wa    = ir_q[25:21];

    assign br_taken = ((iclass == CL_BNE) && !alu_eq) ||
                      ((iclass == CL_BLT) && alu_lt) ||
                      ((iclass == CL_BLE) && (alu_lt || alu_eq));

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_INC;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_src    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                ir_d     = Instruction;
                state_d  = DECODE;
            end
            DECODE: begin
                case (iclass)
                    CL_NOOP: state_d = FETCH;
                    CL_ILLEGAL: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                    CL_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        state_d  = FETCH;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                if (is_branch(iclass)) begin
                    pc_write = br_taken;
                    pc_src   = PC_SRC_BRANCH;
                    state_d  = FETCH;
                end else if (iclass == CL_LWI || iclass == CL_SWI) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (iclass == CL_SWI) begin
                    mem_write = 1'b1;
                    state_d   = FETCH;
                end else begin
                    mem_read = 1'b1;
                    state_d  = WB;
                end
            end
            WB: begin
                reg_write = 1'b1;
                wb_src    = (iclass == CL_LWI);
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // An instruction caught by reset must not commit anything in that cycle.
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // An instruction retires whenever the FSM re-enters FETCH from elsewhere.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q;
        if (state_d == FETCH && state_q != FETCH) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: each instruction is
// expanded by a per-instruction cycle model and compared cycle by cycle.
module tb_multicycle_control;
    import mc_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic        alu_eq;
    logic        alu_lt;
    logic [31:0] ir;
    logic [4:0]  ra_a, ra_b, wa;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src_b;
    logic        ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        mem_read, mem_write, reg_write, wb_src, illegal;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .Instruction (Instruction),
        .alu_eq      (alu_eq),
        .alu_lt      (alu_lt),
        .ir          (ir),
        .ra_a        (ra_a),
        .ra_b        (ra_b),
        .wa          (wa),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_b   (alu_src_b),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .wb_src      (wb_src),
        .illegal     (illegal),
        .state       (state)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_cycles = 0;
    int m_instr  = 0;

    typedef enum int {
        K_NOOP, K_J, K_ADD, K_SLT, K_BNE, K_BLT, K_BLE,
        K_ADDI, K_LI, K_LUI, K_LWI, K_SWI, K_UNDEF
    } kind_e;

    logic [5:0] legal_ops [12] = '{
        6'b000000, 6'b000001, 6'b010010, 6'b010111, 6'b100001, 6'b100010,
        6'b100011, 6'b110010, 6'b111001, 6'b111010, 6'b111011, 6'b111100
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic kind_e classify(input logic [5:0] op);
        case (op)
            6'b000000: return K_NOOP;
            6'b000001: return K_J;
            6'b010010: return K_ADD;
            6'b010111: return K_SLT;
            6'b100001: return K_BNE;
            6'b100010: return K_BLT;
            6'b100011: return K_BLE;
            6'b110010: return K_ADDI;
            6'b111001: return K_LI;
            6'b111010: return K_LUI;
            6'b111011: return K_LWI;
            6'b111100: return K_SWI;
            default:   return K_UNDEF;
        endcase
    endfunction

    // Runs one instruction starting in its FETCH cycle; abort_at >= 0 raises
    // rst in that cycle index and checks the abort instead of completing.
    task automatic run_instr(input logic [31:0] word, input logic eq, input logic lt,
                             input int abort_at);
        kind_e       k;
        logic        is_br, taken, uses_alu, is_mem;
        int          n;
        logic [4:0]  e_ra_a, e_ra_b;
        logic [31:0] e_imm;
        logic [3:0]  e_alu_op;
        logic        e_src_b;
        string       pfx;

        k        = classify(word[31:26]);
        is_br    = (k == K_BNE) || (k == K_BLT) || (k == K_BLE);
        is_mem   = (k == K_LWI) || (k == K_SWI);
        uses_alu = !(k == K_NOOP || k == K_J || k == K_UNDEF);
        taken    = (k == K_BNE && !eq) || (k == K_BLT && lt) || (k == K_BLE && (lt || eq));

        if (k == K_NOOP || k == K_J || k == K_UNDEF) n = 2;
        else if (is_br)                              n = 3;
        else if (k == K_LWI)                         n = 5;
        else                                         n = 4;

        e_ra_a = (is_br || k == K_SWI || k == K_LUI) ? word[25:21] : word[20:16];
        e_ra_b = is_br ? word[20:16] : word[15:11];
        e_imm  = (k == K_ADDI || is_br) ? {{16{word[15]}}, word[15:0]} : {16'h0000, word[15:0]};
        case (k)
            K_SLT:        e_alu_op = ALU_SLT;
            K_LI:         e_alu_op = ALU_PASS_B;
            K_LWI, K_SWI: e_alu_op = ALU_PASS_B;
            K_LUI:        e_alu_op = ALU_LUI_MERGE;
            K_BNE, K_BLT, K_BLE: e_alu_op = ALU_SUB;
            default:      e_alu_op = ALU_ADD;
        endcase
        e_src_b = !(k == K_ADD || k == K_SLT || is_br);

        for (int c = 0; c < n; c++) begin
            logic [2:0] e_state;
            logic       e_irw, e_pcw, e_mr, e_mw, e_rw, e_wbs, e_ill;
            logic [1:0] e_pcs;

            pfx         = $sformatf("%s@%08h c%0d", k.name(), word, c);
            Instruction = (c == 0) ? word : $urandom;
            alu_eq      = (c == 2) ? eq : 1'($urandom_range(0, 1));
            alu_lt      = (c == 2) ? lt : 1'($urandom_range(0, 1));

            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({pfx, " abort strobes"},
                      {26'd0, ir_write, pc_write, mem_read, mem_write, reg_write, illegal}, 32'd0);
                @(posedge clk);
                #1;
                check({pfx, " abort state"}, {29'd0, state}, 32'd0);
                check({pfx, " abort ir"}, ir, 32'd0);
                rst      = 1'b0;
                m_cycles = 0;
                m_instr  = 0;
                return;
            end

            e_irw = 0; e_pcw = 0; e_pcs = 0; e_mr = 0; e_mw = 0; e_rw = 0; e_wbs = 0; e_ill = 0;
            if (c == 0) begin
                e_state = 3'd0;
                e_irw = 1; e_pcw = 1; e_pcs = 2'd0;
            end else if (c == 1) begin
                e_state = 3'd1;
                if (k == K_J)     begin e_pcw = 1; e_pcs = 2'd1; end
                if (k == K_UNDEF) e_ill = 1;
            end else if (c == 2) begin
                e_state = 3'd2;
                if (is_br && taken) begin e_pcw = 1; e_pcs = 2'd2; end
            end else if (c == 3 && is_mem) begin
                e_state = 3'd3;
                e_mw = (k == K_SWI);
                e_mr = (k == K_LWI);
            end else begin
                e_state = 3'd4;
                e_rw  = 1;
                e_wbs = (k == K_LWI);
            end

            @(negedge clk);
            check({pfx, " state"}, {29'd0, state}, {29'd0, e_state});
            check({pfx, " strobes"},
                  {26'd0, ir_write, pc_write, mem_read, mem_write, reg_write, illegal},
                  {26'd0, e_irw, e_pcw, e_mr, e_mw, e_rw, e_ill});
            if (e_pcw) check({pfx, " pc_src"}, {30'd0, pc_src}, {30'd0, e_pcs});
            if (e_rw)  check({pfx, " wb_src"}, {31'd0, wb_src}, {31'd0, e_wbs});
            if (c >= 1) begin
                check({pfx, " ir"}, ir, word);
                check({pfx, " wa"}, {27'd0, wa}, {27'd0, word[25:21]});
                check({pfx, " ra_a"}, {27'd0, ra_a}, {27'd0, e_ra_a});
                check({pfx, " ra_b"}, {27'd0, ra_b}, {27'd0, e_ra_b});
                check({pfx, " imm"}, imm, e_imm);
                if (uses_alu) begin
                    check({pfx, " alu_op"}, {28'd0, alu_op}, {28'd0, e_alu_op});
                    check({pfx, " alu_src_b"}, {31'd0, alu_src_b}, {31'd0, e_src_b});
                end
            end
`ifdef MC_PERF_CNT_EN
            if (c == 0) begin
                check({pfx, " instr_cnt"}, instr_cnt, 32'(m_instr));
                check({pfx, " cycle_cnt"}, cycle_cnt, 32'(m_cycles));
            end
`endif
            @(posedge clk);
            #1;
            m_cycles++;
        end
        m_instr++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach summary within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [5:0]  op;

        rst         = 1'b1;
        Instruction = 32'hE400FFFF;
        alu_eq      = 1'b0;
        alu_lt      = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset state", {29'd0, state}, 32'd0);
        check("reset ir", ir, 32'd0);
        check("reset strobes",
              {26'd0, ir_write, pc_write, mem_read, mem_write, reg_write, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(32'hE400FFFF, 1'b0, 1'b0, -1);  // LI R0,0xFFFF
        run_instr(32'hE800FFFF, 1'b0, 1'b0, -1);  // LUI R0,0xFFFF
        run_instr(32'h48601000, 1'b0, 1'b0, -1);  // ADD R3,R0,R2
        run_instr(32'hF0600005, 1'b0, 1'b0, -1);  // SWI R3,[5]
        run_instr(32'hEC200005, 1'b0, 1'b0, -1);  // LWI R1,[5]
        run_instr(32'h87F7FFFD, 1'b0, 1'b0, -1);  // BNE taken
        run_instr(32'h87F7FFFD, 1'b1, 1'b0, -1);  // BNE not taken
        run_instr(32'h8FF7FFFD, 1'b1, 1'b0, -1);  // BLE taken on equal
        run_instr(32'h8BF7FFFD, 1'b0, 1'b1, -1);  // BLT taken
        run_instr(32'h04000015, 1'b0, 1'b0, -1);  // J 21
        run_instr(32'hFC000000, 1'b0, 1'b0, -1);  // undefined opcode
        run_instr(32'h00000000, 1'b0, 1'b0, -1);  // NOOP
        run_instr(32'hC8221234, 1'b0, 1'b0, 3);   // ADDI aborted in WB
        run_instr(32'hC822F234, 1'b0, 1'b0, -1);  // ADDI negative imm

        for (int i = 0; i < 200; i++) begin
            int idx;
            idx = $urandom_range(0, 12);
            r   = $urandom;
            op  = (idx == 12) ? r[31:26] : legal_ops[idx];
            r   = $urandom;
            run_instr({op, r[25:0]}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
